// File: rtl/stf_sample_gate.sv
// stf_sample_gate: lookback gate between sync_short and the long-preamble synchroniser.
// Keeps the most recent LOOKBACK I/Q samples; on a short-preamble detection it replays
// them oldest-first and then passes live samples until frame end or a lock timeout.
// Optional build macro: STF_GATE_STATS_EN adds detection/timeout statistics counters.
module stf_sample_gate #(
    parameter int unsigned LOOKBACK = 16,
    parameter int unsigned TIMEOUT  = 320
) (
    input  logic        clk,
    input  logic        g_reset,
    input  logic        enable,
    input  logic [31:0] sample_in,
    input  logic        sample_in_strobe,
    input  logic        short_preamble_detected,
    input  logic        long_sync_locked,
    input  logic        demod_done,
    output logic [31:0] sample_out,
    output logic        sample_out_strobe,
    output logic        frame_active,
    output logic        abort,
    output logic [15:0] detect_count,
    output logic [15:0] abort_count
);

    localparam int unsigned AW = $clog2(LOOKBACK);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {StIdle, StActive, StLocked} state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] count_q, count_d;
    logic [31:0]   mem_q [LOOKBACK];
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;

    logic [31:0] sample_out_d;
    logic        sample_out_strobe_d;
    logic        frame_active_d;
    logic        abort_d;

    logic fifo_empty, fifo_full;
    logic detect_acc, timeout_hit, done_hit, flush;
    logic wr_en, rd_en, drop, pop;

    // Event decode shared by the FSM, FIFO and output logic
    always_comb begin
        fifo_empty  = (count_q == '0);
        fifo_full   = (count_q == PW'(LOOKBACK));
        detect_acc  = enable && (state_q == StIdle) && short_preamble_detected;
        timeout_hit = enable && (state_q == StActive) && sample_in_strobe &&
                      (tmo_cnt_q == TW'(TIMEOUT - 1));
        done_hit    = enable && (state_q == StLocked) && demod_done;
        flush       = !enable || timeout_hit || done_hit;
        wr_en       = enable && sample_in_strobe;
        // A read in the final frame cycle still goes out; the flush lands on the same edge
        rd_en       = (state_q != StIdle) && !fifo_empty;
        // In IDLE a write into a full lookback discards the oldest entry
        drop        = (state_q == StIdle) && wr_en && fifo_full;
        pop         = rd_en || drop;
    end

    // State register
    always_ff @(posedge clk) begin
        if (g_reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; enable low overrides every transition
    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (short_preamble_detected) state_d = StActive;
                end
                StActive: begin
                    if (timeout_hit)           state_d = StIdle;
                    else if (long_sync_locked) state_d = StLocked;
                end
                StLocked: begin
                    if (demod_done) state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Output next-values; outputs are registered one cycle behind the read
    always_comb begin
        sample_out_d        = rd_en ? mem_q[rd_ptr_q[AW-1:0]] : sample_out;
        sample_out_strobe_d = rd_en;
        frame_active_d      = (state_d != StIdle);
        abort_d             = timeout_hit;
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (g_reset) begin
            sample_out        <= '0;
            sample_out_strobe <= 1'b0;
            frame_active      <= 1'b0;
            abort             <= 1'b0;
        end else begin
            sample_out        <= sample_out_d;
            sample_out_strobe <= sample_out_strobe_d;
            frame_active      <= frame_active_d;
            abort             <= abort_d;
        end
    end

    // FIFO pointer/count and timeout counter next-state
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        tmo_cnt_d = tmo_cnt_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_en) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)   rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + PW'(wr_en) - PW'(pop);
        end
        if (detect_acc) begin
            tmo_cnt_d = '0;
        end else if (enable && (state_q == StActive) && sample_in_strobe) begin
            tmo_cnt_d = tmo_cnt_q + TW'(1);
        end
    end

    // FIFO control registers
    always_ff @(posedge clk) begin
        if (g_reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            tmo_cnt_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

    // Sample storage; contents need no reset since count gates every read
    always_ff @(posedge clk) begin
        if (!g_reset && wr_en && !flush) begin
            mem_q[wr_ptr_q[AW-1:0]] <= sample_in;
        end
    end

`ifdef STF_GATE_STATS_EN
    logic [15:0] detect_count_q, abort_count_q;

    // Statistics counters, wrapping, cleared only by reset
    always_ff @(posedge clk) begin
        if (g_reset) begin
            detect_count_q <= '0;
            abort_count_q  <= '0;
        end else begin
            if (detect_acc)  detect_count_q <= detect_count_q + 16'd1;
            if (timeout_hit) abort_count_q  <= abort_count_q + 16'd1;
        end
    end

    assign detect_count = detect_count_q;
    assign abort_count  = abort_count_q;
`else
    assign detect_count = '0;
    assign abort_count  = '0;
`endif

endmodule

// File: tb/tb_stf_sample_gate.sv
// Self-checking bench for stf_sample_gate: directed test-plan scenarios followed by a
// randomized phase, all checked cycle by cycle against a queue-based reference model.
module tb_stf_sample_gate;

    localparam int unsigned LOOKBACK = 16;
    localparam int unsigned TIMEOUT  = 320;

    logic        clk;
    logic        g_reset;
    logic        enable;
    logic [31:0] sample_in;
    logic        sample_in_strobe;
    logic        short_preamble_detected;
    logic        long_sync_locked;
    logic        demod_done;
    logic [31:0] sample_out;
    logic        sample_out_strobe;
    logic        frame_active;
    logic        abort;
    logic [15:0] detect_count;
    logic [15:0] abort_count;

    int n_checks = 0;
    int n_fail   = 0;

    typedef enum int {MIdle, MActive, MLocked} mmode_e;

    // Reference model state
    mmode_e      m_mode;
    logic [31:0] m_q[$];
    int          m_tcount;
    logic [31:0] m_out;
    logic        m_stb, m_fa, m_abort;
    logic [15:0] m_det, m_abt;

    // Observation helpers for directed checks
    logic [31:0] seen[$];
    int          abort_seen;
    logic [31:0] vals[50];

    stf_sample_gate #(
        .LOOKBACK(LOOKBACK),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk                    (clk),
        .g_reset                (g_reset),
        .enable                 (enable),
        .sample_in              (sample_in),
        .sample_in_strobe       (sample_in_strobe),
        .short_preamble_detected(short_preamble_detected),
        .long_sync_locked       (long_sync_locked),
        .demod_done             (demod_done),
        .sample_out             (sample_out),
        .sample_out_strobe      (sample_out_strobe),
        .frame_active           (frame_active),
        .abort                  (abort),
        .detect_count           (detect_count),
        .abort_count            (abort_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance the model by one cycle using the inputs currently applied
    task automatic model_step();
        m_abort = 1'b0;
        m_stb   = 1'b0;
        if (g_reset) begin
            m_q.delete();
            m_mode = MIdle;
            m_out  = '0;
            m_fa   = 1'b0;
            m_det  = '0;
            m_abt  = '0;
            return;
        end
        if (m_mode != MIdle && m_q.size() > 0) begin
            m_out = m_q.pop_front();
            m_stb = 1'b1;
        end
        if (!enable) begin
            m_q.delete();
            m_mode = MIdle;
        end else begin
            case (m_mode)
                MIdle: begin
                    if (sample_in_strobe) begin
                        m_q.push_back(sample_in);
                        if (m_q.size() > LOOKBACK) void'(m_q.pop_front());
                    end
                    if (short_preamble_detected) begin
                        m_mode   = MActive;
                        m_tcount = 0;
                        m_det    = m_det + 16'd1;
                    end
                end
                MActive: begin
                    if (sample_in_strobe) begin
                        m_q.push_back(sample_in);
                        m_tcount++;
                    end
                    if (m_tcount == TIMEOUT) begin
                        m_abort = 1'b1;
                        m_q.delete();
                        m_mode = MIdle;
                        m_abt  = m_abt + 16'd1;
                    end else if (long_sync_locked) begin
                        m_mode = MLocked;
                    end
                end
                default: begin
                    if (demod_done) begin
                        m_q.delete();
                        m_mode = MIdle;
                    end else if (sample_in_strobe) begin
                        m_q.push_back(sample_in);
                    end
                end
            endcase
        end
        m_fa = (m_mode != MIdle);
    endtask

    task automatic compare();
        check("strobe", 32'(sample_out_strobe), 32'(m_stb));
        check("frame_active", 32'(frame_active), 32'(m_fa));
        check("abort", 32'(abort), 32'(m_abort));
        if (m_stb) check("data", sample_out, m_out);
`ifdef STF_GATE_STATS_EN
        check("detect_count", 32'(detect_count), 32'(m_det));
        check("abort_count", 32'(abort_count), 32'(m_abt));
`else
        check("detect_count_tied", 32'(detect_count), 32'd0);
        check("abort_count_tied", 32'(abort_count), 32'd0);
`endif
        if (sample_out_strobe) seen.push_back(sample_out);
        if (abort) abort_seen++;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        compare();
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic strobe_sample(input logic [31:0] v);
        sample_in        = v;
        sample_in_strobe = 1'b1;
        tick();
        sample_in_strobe = 1'b0;
    endtask

    task automatic pulse_det();
        short_preamble_detected = 1'b1;
        tick();
        short_preamble_detected = 1'b0;
    endtask

    initial begin
        g_reset                 = 1'b1;
        enable                  = 1'b0;
        sample_in               = '0;
        sample_in_strobe        = 1'b0;
        short_preamble_detected = 1'b0;
        long_sync_locked        = 1'b0;
        demod_done              = 1'b0;
        abort_seen              = 0;
        m_mode                  = MIdle;
        m_tcount                = 0;
        idle(2);
        check("rst_sample_out", sample_out, 32'd0);
        check("rst_frame_active", 32'(frame_active), 32'd0);
        g_reset = 1'b0;
        enable  = 1'b1;
        idle(2);

        // Warm-up and replay
        for (int i = 1; i <= 40; i++) begin
            strobe_sample(32'(i));
            idle(4);
        end
        seen.delete();
        pulse_det();
        check("fa_rise", 32'(frame_active), 32'd1);
        idle(17);
        check("replay_len", 32'(seen.size()), 32'd16);
        for (int k = 0; k < 16 && k < seen.size(); k++) begin
            check("replay_val", seen[k], 32'(25 + k));
        end
        seen.delete();
        strobe_sample(32'd41);
        check("live_not_early", 32'(seen.size()), 32'd0);
        tick();
        check("live_latency", 32'(seen.size()), 32'd1);
        if (seen.size() > 0) check("live_val", seen[0], 32'd41);
        long_sync_locked = 1'b1;
        idle(2);
        demod_done = 1'b1;
        tick();
        demod_done       = 1'b0;
        long_sync_locked = 1'b0;
        idle(3);

        // Short history
        seen.delete();
        for (int i = 0; i < 3; i++) begin
            strobe_sample(32'(100 + i));
            idle(1);
        end
        pulse_det();
        idle(6);
        check("short_len", 32'(seen.size()), 32'd3);
        for (int k = 0; k < 3 && k < seen.size(); k++) check("short_val", seen[k], 32'(100 + k));
        strobe_sample(32'd103);
        idle(2);
        check("short_live_len", 32'(seen.size()), 32'd4);
        if (seen.size() > 3) check("short_live_val", seen[3], 32'd103);

        // Enable drop mid-frame, then confirm the FIFO was emptied
        abort_seen = 0;
        enable = 1'b0;
        tick();
        check("en_drop_fa", 32'(frame_active), 32'd0);
        check("en_drop_abort", 32'(abort_seen), 32'd0);
        enable = 1'b1;
        idle(1);
        seen.delete();
        pulse_det();
        idle(4);
        check("en_flush_empty", 32'(seen.size()), 32'd0);

        // Timeout with lock held low
        abort_seen = 0;
        for (int i = 1; i <= int'(TIMEOUT); i++) begin
            idle($urandom_range(0, 2));
            strobe_sample($urandom);
            if (i == int'(TIMEOUT)) begin
                check("abort_pulse", 32'(abort), 32'd1);
                check("abort_fa", 32'(frame_active), 32'd0);
            end
        end
        idle(3);
        check("abort_once", 32'(abort_seen), 32'd1);
`ifdef STF_GATE_STATS_EN
        check("abort_count_1", 32'(abort_count), 32'd1);
`endif
        seen.delete();
        pulse_det();
        idle(3);
        check("tmo_flush_empty", 32'(seen.size()), 32'd0);

        // Lock at the 100th strobe, done at the 1000th
        abort_seen = 0;
        for (int i = 1; i <= 1000; i++) begin
            idle($urandom_range(0, 2));
            if (i == 100) long_sync_locked = 1'b1;
            if (i == 1000) demod_done = 1'b1;
            strobe_sample($urandom);
            demod_done = 1'b0;
        end
        long_sync_locked = 1'b0;
        check("no_abort_locked", 32'(abort_seen), 32'd0);
        idle(2);
        seen.delete();
        idle(3);
        check("done_stop", 32'(seen.size()), 32'd0);
        check("done_fa", 32'(frame_active), 32'd0);
        for (int i = 0; i < 50; i++) begin
            vals[i] = $urandom;
            strobe_sample(vals[i]);
            idle($urandom_range(0, 1));
        end
        seen.delete();
        pulse_det();
        idle(18);
        check("second_len", 32'(seen.size()), 32'd16);
        for (int k = 0; k < 16 && k < seen.size(); k++) check("second_val", seen[k], vals[34 + k]);

        // Detections while LOCKED are ignored
        long_sync_locked = 1'b1;
        idle(2);
        pulse_det();
        idle(1);
        pulse_det();
`ifdef STF_GATE_STATS_EN
        check("det_ignored", 32'(detect_count), 32'd5);
`endif
        long_sync_locked = 1'b0;
        abort_seen = 0;
        enable = 1'b0;
        tick();
        enable = 1'b1;
        check("locked_drop_fa", 32'(frame_active), 32'd0);
        check("locked_drop_abort", 32'(abort_seen), 32'd0);
        idle(2);

        // Reset mid-replay
        for (int i = 0; i < 20; i++) strobe_sample($urandom);
        pulse_det();
        idle(5);
        g_reset = 1'b1;
        tick();
        check("rst_mid_out", sample_out, 32'd0);
        check("rst_mid_stb", 32'(sample_out_strobe), 32'd0);
        check("rst_mid_fa", 32'(frame_active), 32'd0);
        check("rst_mid_abort", 32'(abort), 32'd0);
        check("rst_mid_detcnt", 32'(detect_count), 32'd0);
        check("rst_mid_abtcnt", 32'(abort_count), 32'd0);
        g_reset = 1'b0;
        idle(2);

        // Randomized phase
        for (int c = 0; c < 3000; c++) begin
            sample_in               = $urandom;
            sample_in_strobe        = ($urandom_range(0, 1) == 1);
            short_preamble_detected = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 59) == 0) long_sync_locked = ~long_sync_locked;
            demod_done              = ($urandom_range(0, 99) == 0);
            enable                  = ($urandom_range(0, 199) != 0);
            g_reset                 = ($urandom_range(0, 999) == 0);
            tick();
        end
        sample_in_strobe        = 1'b0;
        short_preamble_detected = 1'b0;
        long_sync_locked        = 1'b0;
        demod_done              = 1'b0;
        enable                  = 1'b1;
        g_reset                 = 1'b0;
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
